// File: rtl/sent_rx_crc_check.sv
// SENT RX CRC checker: snapshots each decoded fast frame or slow message and
// recomputes its SAE J2716 CRC-4/CRC-6 bit-serially against the received CRC.
module sent_rx_crc_check #(
  parameter logic [3:0] CRC4_SEED = 4'h5,
  parameter logic [5:0] CRC6_SEED = 6'h15,
  parameter int         ERR_CNT_W = 8
) (
  input  logic                 clk_rx,
  input  logic                 reset_rx,
  input  logic [2:0]           done_pre_data,
  input  logic [27:0]          data_fast_check_crc,
  input  logic [29:0]          data_channel_check_crc,
  output logic                 crc_valid,
  output logic                 crc_ok,
  output logic                 crc_error,
  output logic [2:0]           crc_type,
  output logic [5:0]           crc_calc,
  output logic [5:0]           crc_recv,
  output logic [23:0]          msg_data,
  output logic                 busy,
  output logic                 overrun,
  output logic [ERR_CNT_W-1:0] err_count
);

  // Handshake: done_pre_data is a level code and a message launches on its
  // 000 -> non-zero edge; there is no ready, so an edge seen while busy is
  // dropped and flagged by overrun. crc_valid is a one-cycle strobe and the
  // result fields hold until the next strobe.

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [ERR_CNT_W-1:0] ERR_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

  state_t      state, state_nxt;
  logic [2:0]  prev_code;
  logic        launch_req, accept, drop, shift_en, finish;

  logic [2:0]  type_q;
  logic [29:0] sreg_q;
  logic [23:0] msg_q;
  logic [5:0]  recv_q;
  logic [5:0]  crc_q;
  logic [4:0]  cnt_q;
  logic [4:0]  nbits_q;
  logic        is6_q;

  logic [29:0] cap_sreg;
  logic [23:0] cap_msg;
  logic [5:0]  cap_recv;
  logic [4:0]  cap_nbits;
  logic        cap_is6;

  logic        shift_bit;
  logic [3:0]  crc4_nxt;
  logic [5:0]  crc6_nxt;
  logic [5:0]  crc_step;
  logic        mismatch;

  assign launch_req = (prev_code == 3'b000) && (done_pre_data != 3'b000) &&
                      (done_pre_data <= 3'b101);

  // FSM state register
  always_ff @(posedge clk_rx) begin
    if (reset_rx) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (launch_req) state_nxt = ST_SHIFT;
      ST_SHIFT: if (cnt_q == nbits_q - 5'd1) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // FSM control outputs
  always_comb begin
    accept   = (state == ST_IDLE) && launch_req;
    drop     = (state != ST_IDLE) && launch_req;
    shift_en = (state == ST_SHIFT);
    finish   = (state == ST_DONE);
  end

  // Message fields are left-aligned in the shifter so the augmentation zeros
  // fall out of the low end for free.
  always_comb begin
    cap_sreg  = '0;
    cap_msg   = '0;
    cap_recv  = '0;
    cap_nbits = '0;
    cap_is6   = 1'b0;
    case (done_pre_data)
      3'b001: begin
        cap_sreg  = {data_fast_check_crc[27:4], 6'b0};
        cap_msg   = data_fast_check_crc[27:4];
        cap_recv  = {2'b00, data_fast_check_crc[3:0]};
        cap_nbits = 5'd28;
      end
      3'b010: begin
        cap_sreg  = {data_fast_check_crc[19:4], 14'b0};
        cap_msg   = {8'b0, data_fast_check_crc[19:4]};
        cap_recv  = {2'b00, data_fast_check_crc[3:0]};
        cap_nbits = 5'd20;
      end
      3'b011: begin
        cap_sreg  = {data_fast_check_crc[15:4], 18'b0};
        cap_msg   = {12'b0, data_fast_check_crc[15:4]};
        cap_recv  = {2'b00, data_fast_check_crc[3:0]};
        cap_nbits = 5'd16;
      end
      3'b100: begin
        cap_sreg  = {data_channel_check_crc[15:4], 18'b0};
        cap_msg   = {12'b0, data_channel_check_crc[15:4]};
        cap_recv  = {2'b00, data_channel_check_crc[3:0]};
        cap_nbits = 5'd16;
      end
      3'b101: begin
        cap_sreg  = {data_channel_check_crc[29:6], 6'b0};
        cap_msg   = data_channel_check_crc[29:6];
        cap_recv  = data_channel_check_crc[5:0];
        cap_nbits = 5'd30;
        cap_is6   = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    shift_bit = sreg_q[29];
    crc4_nxt  = {crc_q[2:0], shift_bit} ^ (crc_q[3] ? 4'hD : 4'h0);
    crc6_nxt  = {crc_q[4:0], shift_bit} ^ (crc_q[5] ? 6'h19 : 6'h00);
    crc_step  = is6_q ? crc6_nxt : {2'b00, crc4_nxt};
    mismatch  = (crc_q != recv_q);
  end

  always_ff @(posedge clk_rx) begin
    if (reset_rx) begin
      prev_code <= 3'b000;
      type_q    <= '0;
      sreg_q    <= '0;
      msg_q     <= '0;
      recv_q    <= '0;
      crc_q     <= '0;
      cnt_q     <= '0;
      nbits_q   <= '0;
      is6_q     <= 1'b0;
    end else begin
      prev_code <= done_pre_data;
      if (accept) begin
        type_q  <= done_pre_data;
        sreg_q  <= cap_sreg;
        msg_q   <= cap_msg;
        recv_q  <= cap_recv;
        nbits_q <= cap_nbits;
        is6_q   <= cap_is6;
        cnt_q   <= '0;
        crc_q   <= cap_is6 ? CRC6_SEED : {2'b00, CRC4_SEED};
      end else if (shift_en) begin
        sreg_q  <= {sreg_q[28:0], 1'b0};
        crc_q   <= crc_step;
        cnt_q   <= cnt_q + 5'd1;
      end
    end
  end

  // busy spans launch through the strobe cycle; a launch in that last cycle
  // re-arms it immediately.
  always_ff @(posedge clk_rx) begin
    if (reset_rx) begin
      crc_valid <= 1'b0;
      crc_ok    <= 1'b0;
      crc_error <= 1'b0;
      crc_type  <= '0;
      crc_calc  <= '0;
      crc_recv  <= '0;
      msg_data  <= '0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      err_count <= '0;
    end else begin
      crc_valid <= finish;
      overrun   <= drop;
      if (accept) begin
        busy <= 1'b1;
      end else if (crc_valid) begin
        busy <= 1'b0;
      end
      if (finish) begin
        crc_calc  <= crc_q;
        crc_recv  <= recv_q;
        crc_ok    <= !mismatch;
        crc_error <= mismatch;
        crc_type  <= type_q;
        msg_data  <= msg_q;
        if (mismatch && !(&err_count)) begin
          err_count <= err_count + ERR_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_sent_rx_crc_check.sv
// Bench for sent_rx_crc_check: directed cases with hand-computed values plus
// randomized traffic checked every cycle against a polynomial-division model.
module tb_sent_rx_crc_check;

  logic        clk_rx = 1'b0;
  logic        reset_rx;
  logic [2:0]  done_pre_data;
  logic [27:0] data_fast_check_crc;
  logic [29:0] data_channel_check_crc;
  logic        crc_valid, crc_ok, crc_error, busy, overrun;
  logic [2:0]  crc_type;
  logic [5:0]  crc_calc, crc_recv;
  logic [23:0] msg_data;
  logic [7:0]  err_count;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clk_rx = ~clk_rx;

  sent_rx_crc_check dut (
    .clk_rx                 (clk_rx),
    .reset_rx               (reset_rx),
    .done_pre_data          (done_pre_data),
    .data_fast_check_crc    (data_fast_check_crc),
    .data_channel_check_crc (data_channel_check_crc),
    .crc_valid              (crc_valid),
    .crc_ok                 (crc_ok),
    .crc_error              (crc_error),
    .crc_type               (crc_type),
    .crc_calc               (crc_calc),
    .crc_recv               (crc_recv),
    .msg_data               (msg_data),
    .busy                   (busy),
    .overrun                (overrun),
    .err_count              (err_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Result packing: [39:37] type, [36:31] calc, [30:25] recv, [24] ok, [23:0] msg.
  function automatic int msg_bits(input logic [2:0] code);
    case (code)
      3'b001: return 28;
      3'b010: return 20;
      3'b011: return 16;
      3'b100: return 16;
      3'b101: return 30;
      default: return 0;
    endcase
  endfunction

  // CRC as remainder of (seed*x^(d+w) + data*x^w) modulo the full polynomial.
  function automatic logic [39:0] model_result(input logic [2:0] code,
                                               input logic [27:0] f,
                                               input logic [29:0] ch);
    int d, w;
    logic [63:0] data, recv, val, poly, seed, calc;
    logic ok;
    d = 0; w = 4; data = '0; recv = '0;
    case (code)
      3'b001: begin d = 24; data = 64'(f[27:4]);  recv = 64'(f[3:0]);  end
      3'b010: begin d = 16; data = 64'(f[19:4]);  recv = 64'(f[3:0]);  end
      3'b011: begin d = 12; data = 64'(f[15:4]);  recv = 64'(f[3:0]);  end
      3'b100: begin d = 12; data = 64'(ch[15:4]); recv = 64'(ch[3:0]); end
      3'b101: begin d = 24; w = 6; data = 64'(ch[29:6]); recv = 64'(ch[5:0]); end
      default: ;
    endcase
    poly = (w == 6) ? 64'h59 : 64'h1D;
    seed = (w == 6) ? 64'h15 : 64'h05;
    val  = (seed << (d + w)) | (data << w);
    for (int i = d + 2 * w - 1; i >= w; i--) begin
      if (val[i]) val = val ^ (poly << (i - w));
    end
    calc = val & ((64'd1 << w) - 64'd1);
    ok   = (calc == recv);
    return {code, calc[5:0], recv[5:0], ok, data[23:0]};
  endfunction

  // ---------------- scoreboard ----------------
  logic [39:0] exp_q[$];
  int          edge_n = 0;
  bit          m_pending = 1'b0;
  int          m_done_edge = 0;
  logic [2:0]  m_prev = 3'b000;
  bit          m_launch, m_comp;
  logic        exp_valid = 1'b0, exp_busy = 1'b0, exp_overrun = 1'b0, exp_error = 1'b0;
  logic [39:0] exp_res = '0;
  logic [7:0]  exp_err = '0;

  always @(posedge clk_rx) begin
    edge_n++;
    if (reset_rx) begin
      exp_q.delete();
      m_pending   = 1'b0;
      exp_valid   = 1'b0;
      exp_busy    = 1'b0;
      exp_overrun = 1'b0;
      exp_error   = 1'b0;
      exp_res     = '0;
      exp_err     = '0;
      m_prev      = 3'b000;
    end else begin
      m_launch    = (m_prev == 3'b000) && (done_pre_data != 3'b000) && (done_pre_data <= 3'd5);
      exp_overrun = m_launch && m_pending;
      exp_valid   = 1'b0;
      m_comp      = 1'b0;
      if (m_pending && edge_n == m_done_edge) begin
        if (exp_q.size() > 0) exp_res = exp_q.pop_front();
        exp_error = !exp_res[24];
        if (!exp_res[24] && exp_err != 8'hFF) exp_err = exp_err + 8'd1;
        exp_valid = 1'b1;
        m_pending = 1'b0;
        m_comp    = 1'b1;
      end
      if (m_launch && !exp_overrun) begin
        exp_q.push_back(model_result(done_pre_data, data_fast_check_crc, data_channel_check_crc));
        m_pending   = 1'b1;
        m_done_edge = edge_n + msg_bits(done_pre_data) + 1;
      end
      exp_busy = m_pending || m_comp;
      m_prev   = done_pre_data;
    end
  end

  always @(negedge clk_rx) begin
    if (chk_en) begin
      check("crc_valid", crc_valid, exp_valid);
      check("busy", busy, exp_busy);
      check("overrun", overrun, exp_overrun);
      check("err_count", err_count, exp_err);
      check("crc_type", crc_type, exp_res[39:37]);
      check("crc_calc", crc_calc, exp_res[36:31]);
      check("crc_recv", crc_recv, exp_res[30:25]);
      check("crc_ok", crc_ok, exp_res[24]);
      check("crc_error", crc_error, exp_error);
      check("msg_data", msg_data, exp_res[23:0]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [2:0] code, input logic [27:0] f, input logic [29:0] ch,
                      input int hold, input int gap);
    @(negedge clk_rx);
    data_fast_check_crc    = f;
    data_channel_check_crc = ch;
    done_pre_data          = code;
    repeat (hold) @(negedge clk_rx);
    done_pre_data = 3'b000;
    repeat (gap - 1) @(negedge clk_rx);
  endtask

  // Launches one message held for 3 cycles and checks its result against
  // hand-computed values; the data inputs are scrambled after capture.
  task automatic directed(input string tag, input logic [2:0] code, input logic [27:0] f,
                          input logic [29:0] ch, input int exp_lat, input logic [5:0] exp_calc,
                          input logic [5:0] exp_recv, input logic exp_ok,
                          input logic [7:0] exp_errc, input logic [23:0] exp_msg);
    int lat;
    lat = -1;
    @(negedge clk_rx);
    data_fast_check_crc    = f;
    data_channel_check_crc = ch;
    done_pre_data          = code;
    for (int j = 0; j < 45 && lat < 0; j++) begin
      @(negedge clk_rx);
      if (j == 1) begin
        data_fast_check_crc    = ~f;
        data_channel_check_crc = ~ch;
      end
      if (j == 2) done_pre_data = 3'b000;
      if (crc_valid) begin
        lat = j;
        check({tag, " calc"}, crc_calc, exp_calc);
        check({tag, " recv"}, crc_recv, exp_recv);
        check({tag, " ok"}, crc_ok, exp_ok);
        check({tag, " error"}, crc_error, !exp_ok);
        check({tag, " type"}, crc_type, code);
        check({tag, " err_count"}, err_count, exp_errc);
        check({tag, " msg"}, msg_data, exp_msg);
      end
    end
    check({tag, " latency"}, lat, exp_lat);
    done_pre_data = 3'b000;
    repeat (2) @(negedge clk_rx);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [39:0] r;
    logic [27:0] f;
    logic [29:0] ch;
    logic [2:0]  code;
    int n_valid, n_busy, lat;

    reset_rx               = 1'b1;
    done_pre_data          = 3'b000;
    data_fast_check_crc    = '0;
    data_channel_check_crc = '0;
    repeat (3) @(posedge clk_rx);
    @(negedge clk_rx);
    chk_en = 1'b1;
    check("reset valid", crc_valid, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset err_count", err_count, 8'h00);
    reset_rx = 1'b0;

    r = model_result(3'b011, 28'h0000009, 30'h0);
    check("model crc4 f3", r[36:31], 6'h09);
    r = model_result(3'b101, 28'h0, 30'h00000026);
    check("model crc6", r[36:31], 6'h26);
    r = model_result(3'b101, 28'h0, 30'h20000026);
    check("model crc6 b29", r[36:31], 6'h30);

    directed("t1",  3'b011, 28'h0000009, 30'h0,        17, 6'h09, 6'h09, 1'b1, 8'd0, 24'h0);
    directed("t2a", 3'b001, 28'h0000005, 30'h0,        29, 6'h05, 6'h05, 1'b1, 8'd0, 24'h0);
    directed("t2b", 3'b001, 28'h0000006, 30'h0,        29, 6'h05, 6'h06, 1'b0, 8'd1, 24'h0);
    directed("t3a", 3'b010, 28'h000000C, 30'h0,        21, 6'h0C, 6'h0C, 1'b1, 8'd1, 24'h0);
    directed("t3b", 3'b100, 28'h0,       30'h9,        17, 6'h09, 6'h09, 1'b1, 8'd1, 24'h0);
    directed("t4a", 3'b101, 28'h0,       30'h26,       31, 6'h26, 6'h26, 1'b1, 8'd1, 24'h0);
    directed("t4b", 3'b101, 28'h0,       30'h20000026, 31, 6'h30, 6'h26, 1'b0, 8'd2, 24'h800000);

    // Second launch while busy is dropped with a single overrun pulse.
    @(negedge clk_rx);
    data_fast_check_crc = 28'h1234567;
    done_pre_data       = 3'b001;
    n_valid = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk_rx);
      if (j == 2)  done_pre_data = 3'b000;
      if (j == 9)  done_pre_data = 3'b011;
      if (j == 10) check("t5 overrun pulse", overrun, 1'b1);
      if (j == 11) check("t5 overrun one cycle", overrun, 1'b0);
      if (j == 12) done_pre_data = 3'b000;
      if (crc_valid) begin
        n_valid++;
        check("t5 type", crc_type, 3'b001);
      end
    end
    check("t5 valid count", n_valid, 1);

    // Reserved code never launches.
    @(negedge clk_rx);
    done_pre_data = 3'b110;
    n_busy = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk_rx);
      if (j == 2) done_pre_data = 3'b000;
      if (busy || crc_valid) n_busy++;
    end
    check("t5 reserved quiet", n_busy, 0);

    // Back-to-back: a launch driven during the strobe cycle is accepted.
    send(3'b011, 28'h0000009, 30'h0, 1, 1);
    lat = -1;
    for (int j = 0; j < 40 && lat < 0; j++) begin
      @(negedge clk_rx);
      if (crc_valid) lat = j;
    end
    data_channel_check_crc = 30'h9;
    done_pre_data          = 3'b100;
    lat = -1;
    for (int j = 0; j < 40 && lat < 0; j++) begin
      @(negedge clk_rx);
      if (j == 2) done_pre_data = 3'b000;
      if (crc_valid) begin
        lat = j;
        check("b2b type", crc_type, 3'b100);
        check("b2b ok", crc_ok, 1'b1);
      end
    end
    check("b2b latency", lat, 17);
    done_pre_data = 3'b000;

    // Reset in mid-computation discards the result.
    @(negedge clk_rx);
    data_fast_check_crc = 28'h0000006;
    done_pre_data       = 3'b001;
    n_valid = 0;
    for (int j = 0; j < 45; j++) begin
      @(negedge clk_rx);
      if (j == 2) done_pre_data = 3'b000;
      if (j == 14) reset_rx = 1'b1;
      if (j == 15) begin
        reset_rx = 1'b0;
        check("t6 reset busy", busy, 1'b0);
        check("t6 reset err_count", err_count, 8'h00);
        check("t6 reset type", crc_type, 3'b000);
        check("t6 reset calc", crc_calc, 6'h00);
        check("t6 reset msg", msg_data, 24'h0);
      end
      if (crc_valid) n_valid++;
    end
    check("t6 no valid after reset", n_valid, 0);

    // Saturation of the error counter.
    for (int k = 0; k < 260; k++) send(3'b011, 28'h0, 30'h0, 1, 19);
    repeat (2) @(negedge clk_rx);
    check("t6 err_count saturated", err_count, 8'hFF);

    // Randomized traffic, including overruns, reserved codes and resets.
    for (int k = 0; k < 400; k++) begin
      code = 3'($urandom_range(0, 7));
      f    = 28'($urandom());
      ch   = 30'($urandom());
      if ($urandom_range(0, 1) == 1) begin
        r = model_result(code, f, ch);
        if (code == 3'b100)      ch[3:0] = r[34:31];
        else if (code == 3'b101) ch[5:0] = r[36:31];
        else                     f[3:0]  = r[34:31];
      end
      if ($urandom_range(0, 29) == 0) begin
        @(negedge clk_rx);
        reset_rx = 1'b1;
        @(negedge clk_rx);
        reset_rx = 1'b0;
      end
      send(code, f, ch, $urandom_range(1, 4), $urandom_range(1, 45));
    end
    repeat (40) @(negedge clk_rx);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
